imem_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the single-cycle MIPS processor's instruction memory. Accepts a big-endian byte stream over a valid/ready handshake, packs it into 32-bit instruction words and writes them to consecutive instruction-memory word addresses starting at 0. It holds the processor in reset until the requested number of words is written, then releases it. This replaces hierarchical memory pokes as the way programs enter the core.

---
 rtl/mips_pkg.sv | 17 +
 rtl/imem_loader.sv | 121 ++++++++++++
 tb/tb_imem_loader.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core and its boot-time support blocks.
//   loader_state_t : control states of the instruction-memory loader
//   WORD_W         : instruction word width in bits
//   BYTES_PER_WORD : stream bytes packed into one instruction word
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    RUN   = 2'd3
  } loader_state_t;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader.sv
// Boot-time program loader. Packs a big-endian byte stream into 32-bit
// instruction words and writes them to consecutive instruction-memory word
// addresses starting at 0, holding the processor in reset until the requested
// number of words has been written.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous, active-low reset
//   start       in   one-cycle load request, honoured in IDLE and RUN only
//   word_count  in   words to load (ADDR_W+1 bits), latched on accepted start
//   byte_valid  in   byte_data valid
//   byte_data   in   stream byte
//   byte_ready  out  loader accepts a byte this cycle (state decode only)
//   imem_we     out  instruction-memory write strobe, one cycle per word
//   imem_addr   out  word address of the write
//   imem_wdata  out  packed instruction word
//   cpu_reset   out  active-high processor reset
//   busy        out  high while loading or writing
//   done        out  high while the processor runs
module imem_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done
);

  // Largest legal load: the whole memory, 2^ADDR_W words.
  localparam logic [ADDR_W:0] MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [1:0]      LAST_IDX  = 2'(BYTES_PER_WORD - 1);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [1:0]        idx_q,   idx_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic              last_word;

  function automatic logic [ADDR_W:0] clamp_count(input logic [ADDR_W:0] c);
    return (c > MAX_COUNT) ? MAX_COUNT : c;
  endfunction

  // Termination is tested before the increment, so addr never wraps even on
  // a full 2^ADDR_W-word load.
  assign last_word = (({1'b0, addr_q} + (ADDR_W+1)'(1)) == count_q);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    count_d = count_q;
    shift_d = shift_q;
    case (state_q)
      IDLE, RUN: begin
        if (start) begin
          count_d = clamp_count(word_count);
          addr_d  = '0;
          idx_d   = '0;
          state_d = (word_count == '0) ? RUN : LOAD;
        end
      end
      LOAD: begin
        if (byte_valid) begin
          // Shifting in from the right leaves the first byte in [31:24].
          shift_d = {shift_q[WORD_W-9:0], byte_data};
          idx_d   = idx_q + 2'd1;
          if (idx_q == LAST_IDX) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (last_word) begin
          state_d = RUN;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      count_q <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      shift_q <= shift_d;
    end
  end

  // Every output is a register or a pure state decode.
  assign byte_ready = (state_q == LOAD);
  assign imem_we    = (state_q == WRITE);
  assign imem_addr  = addr_q;
  assign imem_wdata = shift_q;
  assign cpu_reset  = (state_q != RUN);
  assign busy       = (state_q == LOAD) || (state_q == WRITE);
  assign done       = (state_q == RUN);

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int AW = 2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   word_count;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          busy;
  logic          done;

  int   checks   = 0;
  int   failures = 0;
  int   nstrobe  = 0;
  bit   chk_busy = 1'b0;
  exp_t exp_q[$];

  imem_loader #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and sample just after the edge; any write strobe is
  // scored against the expected-write queue.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (imem_we === 1'b1) begin
      nstrobe++;
      chk("unexpected_we", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("waddr", 64'(imem_addr), 64'(e.addr));
        chk("wdata", 64'(imem_wdata), 64'(e.data));
        chk("cpu_reset_in_write", 64'(cpu_reset), 64'd1);
      end
    end
    if (chk_busy) chk("busy_held", 64'(busy), 64'd1);
  endtask

  task automatic pulse_start(input logic [AW:0] wc);
    word_count = wc;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit sent;
    sent = 1'b0;
    repeat (gap) tick();
    byte_data  = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 20 && !sent; i++) begin
      if (byte_ready === 1'b1) sent = 1'b1;
      tick();
    end
    if (!sent) chk("byte_timeout", 64'(byte_ready), 64'd1);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [AW-1:0] a, input logic [31:0] w,
                           input int gap, input bit first);
    exp_t e;
    e.addr = a;
    e.data = w;
    exp_q.push_back(e);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[31-8*k -: 8], (first && k == 0) ? 0 : gap);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cpu_reset"},  64'(cpu_reset),  64'd1);
    chk({tag, "_imem_we"},    64'(imem_we),    64'd0);
    chk({tag, "_imem_addr"},  64'(imem_addr),  64'd0);
    chk({tag, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
    chk({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
    chk({tag, "_busy"},       64'(busy),       64'd0);
    chk({tag, "_done"},       64'(done),       64'd0);
  endtask

  initial begin
    int s0;
    reset      = 1'b0;
    start      = 1'b0;
    word_count = '0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;

    // Power-on reset
    tick();
    tick();
    check_reset_vals("por");
    reset = 1'b1;
    tick();

    // Two words, back-to-back bytes
    s0 = nstrobe;
    pulse_start(3'd2);
    chk("t1_ready_after_start", 64'(byte_ready), 64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    send_word(2'd0, 32'h0022_1820, 0, 1'b1);
    send_word(2'd1, 32'h0062_6022, 0, 1'b0);
    tick();
    chk("t1_cpu_reset_released", 64'(cpu_reset), 64'd0);
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_strobes", 64'(nstrobe - s0), 64'd2);
    chk("t1_missing_we", 64'(exp_q.size()), 64'd0);

    // Same stream with 3-cycle stalls between bytes (restart from RUN)
    s0 = nstrobe;
    pulse_start(3'd2);
    chk_busy = 1'b1;
    send_word(2'd0, 32'h0022_1820, 3, 1'b1);
    send_word(2'd1, 32'h0062_6022, 3, 1'b0);
    chk_busy = 1'b0;
    tick();
    chk("t2_done", 64'(done), 64'd1);
    chk("t2_strobes", 64'(nstrobe - s0), 64'd2);
    chk("t2_missing_we", 64'(exp_q.size()), 64'd0);

    // word_count = 0 from IDLE
    reset = 1'b0;
    tick();
    reset = 1'b1;
    s0 = nstrobe;
    pulse_start(3'd0);
    chk("t3_done", 64'(done), 64'd1);
    chk("t3_cpu_reset", 64'(cpu_reset), 64'd0);
    chk("t3_busy", 64'(busy), 64'd0);
    repeat (3) tick();
    chk("t3_strobes", 64'(nstrobe - s0), 64'd0);

    // Reset after two bytes of word 0 discards the partial word
    s0 = nstrobe;
    pulse_start(3'd1);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    reset = 1'b0;
    tick();
    check_reset_vals("t4_rst");
    reset = 1'b1;
    repeat (3) tick();
    chk("t4_no_write", 64'(nstrobe - s0), 64'd0);
    chk("t4_idle_cpu_reset", 64'(cpu_reset), 64'd1);
    pulse_start(3'd1);
    send_word(2'd0, 32'hAABB_CCDD, 0, 1'b1);
    tick();
    chk("t4_done", 64'(done), 64'd1);
    chk("t4_missing_we", 64'(exp_q.size()), 64'd0);

    // Start pulsed in RUN reasserts the processor reset
    pulse_start(3'd1);
    chk("t5_cpu_reset_reasserted", 64'(cpu_reset), 64'd1);
    chk("t5_done_low", 64'(done), 64'd0);
    send_word(2'd0, 32'h0800_0004, 0, 1'b1);
    tick();
    chk("t5_cpu_reset_released", 64'(cpu_reset), 64'd0);
    chk("t5_missing_we", 64'(exp_q.size()), 64'd0);

    // Full 2^AW-word load with start pulses in LOAD and WRITE ignored
    s0 = nstrobe;
    pulse_start(3'd4);
    send_word(2'd0, 32'h1111_0001, 0, 1'b1);
    tick();
    pulse_start(3'd1);
    chk("t6_start_ignored_load", 64'(busy), 64'd1);
    send_word(2'd1, 32'h2222_0002, 0, 1'b1);
    pulse_start(3'd1);
    send_word(2'd2, 32'h3333_0003, 0, 1'b1);
    send_word(2'd3, 32'h4444_0004, 0, 1'b0);
    tick();
    chk("t6_done", 64'(done), 64'd1);
    chk("t6_strobes", 64'(nstrobe - s0), 64'd4);
    chk("t6_missing_we", 64'(exp_q.size()), 64'd0);

    // Oversized count clamps to the full memory
    s0 = nstrobe;
    pulse_start(3'd6);
    send_word(2'd0, 32'hDEAD_0000, 0, 1'b1);
    send_word(2'd1, 32'hDEAD_0001, 0, 1'b0);
    send_word(2'd2, 32'hDEAD_0002, 0, 1'b0);
    send_word(2'd3, 32'hDEAD_0003, 0, 1'b0);
    tick();
    chk("t7_done", 64'(done), 64'd1);
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    repeat (3) tick();
    byte_valid = 1'b0;
    chk("t7_ready_in_run", 64'(byte_ready), 64'd0);
    chk("t7_strobes", 64'(nstrobe - s0), 64'd4);
    chk("t7_missing_we", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
